// File: rtl/pmp_checker_pipe_if.sv
// pmp_checker_pipe_if: PMP configuration, request, response and fault-log signals of pmp_checker_pipe
interface pmp_checker_pipe_if #(
    parameter int PMP_CNT = 16,
    parameter int PLEN = 34
);
    localparam int EW = PMP_CNT > 1 ? $clog2(PMP_CNT) : 1;
    logic [PMP_CNT-1:0][7:0] io_pmpcfg;
    logic [PMP_CNT-1:0][PLEN-3:0] io_pmpaddr;
    logic io_req_valid;
    logic io_req_ready;
    logic [1:0] io_req_prv;
    logic [PLEN-1:0] io_req_addr;
    logic [1:0] io_req_size;
    logic io_req_r;
    logic io_req_w;
    logic io_req_x;
    logic io_rsp_valid;
    logic io_rsp_ready;
    logic io_rsp_exception;
    logic io_rsp_hit;
    logic [EW-1:0] io_rsp_entry;
    logic io_fault_valid;
    logic [PLEN-1:0] io_fault_addr;
    logic io_fault_clr;
    modport master (
        output io_pmpcfg, io_pmpaddr, io_req_valid, io_req_prv, io_req_addr, io_req_size,
               io_req_r, io_req_w, io_req_x, io_rsp_ready, io_fault_clr,
        input  io_req_ready, io_rsp_valid, io_rsp_exception, io_rsp_hit, io_rsp_entry,
               io_fault_valid, io_fault_addr
    );
    modport slave (
        input  io_pmpcfg, io_pmpaddr, io_req_valid, io_req_prv, io_req_addr, io_req_size,
               io_req_r, io_req_w, io_req_x, io_rsp_ready, io_fault_clr,
        output io_req_ready, io_rsp_valid, io_rsp_exception, io_rsp_hit, io_rsp_entry,
               io_fault_valid, io_fault_addr
    );
endinterface

// File: rtl/pmp_checker_pipe.sv
// pmp_checker_pipe: two-stage PMP access checker (S1 per-entry match/permission, S2 priority resolve).
// Define PMP_FAULT_LOG_EN to build the sticky fault-address log.
module pmp_checker_pipe #(
    parameter int PMP_CNT = 16,
    parameter int PLEN = 34
) (
    input logic clock,
    input logic reset,
    pmp_checker_pipe_if.slave bus
);
    localparam int AW = PLEN - 2;
    localparam int EW = PMP_CNT > 1 ? $clog2(PMP_CNT) : 1;

    logic s1_valid, s2_valid, s1_adv, s2_adv, accept, m_mode, s1_m;
    logic [PMP_CNT-1:0] hit_d, ok_d, s1_hit, s1_ok;
    logic [PLEN-1:0] last_byte;
    logic [AW-1:0] a_first, a_last;
    logic [EW-1:0] idx, rsp_entry;
    logic exc_d, rsp_exc, rsp_hit;

    function automatic logic match(input logic [1:0] mode, input logic [AW-1:0] lo, hi, a);
        return mode == 2'd1 ? (a >= lo && a < hi) :
               mode == 2'd2 ? a == hi :
               mode == 2'd3 ? ((a ^ hi) & ~(hi ^ (hi + 1'b1))) == '0 : 1'b0;
    endfunction

    assign s2_adv = !s2_valid || bus.io_rsp_ready;
    assign s1_adv = !s1_valid || s2_adv;
    assign accept = bus.io_req_valid && s1_adv;
    assign bus.io_req_ready = s1_adv;
    assign last_byte = bus.io_req_addr + (PLEN'(1) << bus.io_req_size) - PLEN'(1);
    assign a_first = bus.io_req_addr[PLEN-1:2];
    assign a_last = last_byte[PLEN-1:2];
    assign m_mode = bus.io_req_prv == 2'd3;

    for (genvar g = 0; g < PMP_CNT; g++) begin : g_entry
        logic [AW-1:0] lo;
        logic mf, ml, perm;
        if (g == 0) begin : g_base
            assign lo = '0;
        end else begin : g_prev
            assign lo = bus.io_pmpaddr[g-1];
        end
        assign mf = match(bus.io_pmpcfg[g][4:3], lo, bus.io_pmpaddr[g], a_first);
        assign ml = match(bus.io_pmpcfg[g][4:3], lo, bus.io_pmpaddr[g], a_last);
        assign perm = |(bus.io_pmpcfg[g][2:0] & {bus.io_req_x, bus.io_req_w, bus.io_req_r});
        assign hit_d[g] = mf || ml;
        // a partial match denies every permission, but unlocked entries never constrain M mode
        assign ok_d[g] = (m_mode && !bus.io_pmpcfg[g][7]) || (mf && ml && perm);
    end

    always_comb begin
        idx = '0;
        for (int i = PMP_CNT - 1; i >= 0; i--) idx = s1_hit[i] ? EW'(i) : idx;
    end
    assign exc_d = |s1_hit ? !s1_ok[idx] : !s1_m;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_hit <= '0;
            s1_ok <= '0;
            s1_m <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.io_req_valid;
            if (bus.io_req_valid) begin
                s1_hit <= hit_d;
                s1_ok <= ok_d;
                s1_m <= m_mode;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            rsp_exc <= 1'b0;
            rsp_hit <= 1'b0;
            rsp_entry <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                rsp_exc <= exc_d;
                rsp_hit <= |s1_hit;
                rsp_entry <= idx;
            end
        end
    end

    assign bus.io_rsp_valid = s2_valid;
    assign bus.io_rsp_exception = rsp_exc;
    assign bus.io_rsp_hit = rsp_hit;
    assign bus.io_rsp_entry = rsp_entry;

`ifdef PMP_FAULT_LOG_EN
    logic [PLEN-1:0] s1_addr, s2_addr, fault_addr;
    logic fault_valid;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_addr <= '0;
            s2_addr <= '0;
            fault_valid <= 1'b0;
            fault_addr <= '0;
        end else begin
            if (accept) s1_addr <= bus.io_req_addr;
            if (s2_adv && s1_valid) s2_addr <= s1_addr;
            // a same-cycle clear lets the new fault in
            if (s2_valid && bus.io_rsp_ready && rsp_exc && (!fault_valid || bus.io_fault_clr)) begin
                fault_valid <= 1'b1;
                fault_addr <= s2_addr;
            end else if (bus.io_fault_clr) begin
                fault_valid <= 1'b0;
            end
        end
    end
    assign bus.io_fault_valid = fault_valid;
    assign bus.io_fault_addr = fault_addr;
`else
    assign bus.io_fault_valid = 1'b0;
    assign bus.io_fault_addr = '0;
`endif
endmodule

// File: tb/tb_pmp_checker_pipe.sv
// tb_pmp_checker_pipe: directed scenarios plus randomized stream checked against a byte-range PMP model
module tb_pmp_checker_pipe;
    localparam int N = 16;
    localparam int PLEN = 34;
    localparam int AW = PLEN - 2;
    localparam int EW = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;

    logic [7:0] cfg [N];
    longint paddr [N];
    logic [1:0] r_prv;
    longint r_addr;
    int r_size, r_kind;

    pmp_checker_pipe_if #(.PMP_CNT(N), .PLEN(PLEN)) bus ();
    pmp_checker_pipe #(.PMP_CNT(N), .PLEN(PLEN)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit in_region(input int i, input longint b);
        longint p, lo, hi, sz;
        int k;
        p = paddr[i];
        lo = 0;
        hi = 0;
        case (cfg[i][4:3])
            2'd1: begin lo = i == 0 ? 0 : paddr[i-1] * 4; hi = p * 4; end
            2'd2: begin lo = p * 4; hi = lo + 4; end
            2'd3: begin
                k = 0;
                while (k < AW && p[k]) k++;
                sz = 64'd1 << (k + 3);
                lo = (p * 4) & ~(sz - 1);
                hi = lo + sz;
            end
            default: ;
        endcase
        return b >= lo && b < hi;
    endfunction

    function automatic logic [EW+1:0] ref_rsp(input logic [1:0] prv, input longint addr,
                                              input int size, input int kind);
        longint last;
        bit m, f, l, ok;
        last = (addr + (64'd1 << size) - 1) % (64'd1 << PLEN);
        m = prv == 2'd3;
        for (int i = 0; i < N; i++) begin
            f = in_region(i, addr);
            l = in_region(i, last);
            if (f || l) begin
                ok = (m && !cfg[i][7]) || (f && l && cfg[i][kind]);
                return {!ok, 1'b1, EW'(i)};
            end
        end
        return {!m, 1'b0, EW'(0)};
    endfunction

    task automatic apply_cfg();
        for (int i = 0; i < N; i++) begin
            bus.io_pmpcfg[i] = cfg[i];
            bus.io_pmpaddr[i] = AW'(paddr[i]);
        end
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < N; i++) begin
            cfg[i] = 8'h00;
            paddr[i] = 0;
        end
        apply_cfg();
    endtask

    task automatic rand_cfg();
        longint base;
        int k;
        for (int i = 0; i < N; i++) begin
            cfg[i] = {1'($urandom), 2'b00, 2'($urandom), 3'($urandom)};
            base = $urandom_range(0, 'h1000);
            k = $urandom_range(0, 7);
            paddr[i] = cfg[i][4:3] == 2'd3 ? (base & ~((64'd2 << k) - 1)) | ((64'd1 << k) - 1) : base;
            if (cfg[i][4:3] == 2'd3 && $urandom_range(0, 15) == 0) paddr[i] = (64'd1 << AW) - 1;
        end
        apply_cfg();
    endtask

    task automatic set_req(input logic [1:0] prv, input longint addr, input int size, input int kind);
        r_prv = prv;
        r_addr = addr;
        r_size = size;
        r_kind = kind;
        bus.io_req_prv = prv;
        bus.io_req_addr = PLEN'(addr);
        bus.io_req_size = 2'(size);
        bus.io_req_r = kind == 0;
        bus.io_req_w = kind == 1;
        bus.io_req_x = kind == 2;
    endtask

    task automatic rand_req();
        longint a;
        if ($urandom_range(0, 3) == 0) rand_cfg();
        a = $urandom_range(0, 9) == 0 ? (64'd1 << PLEN) - $urandom_range(1, 8) : $urandom_range(0, 'h4400);
        set_req(2'($urandom), a, $urandom_range(0, 3), $urandom_range(0, 2));
    endtask

    function automatic logic [EW+1:0] rsp_vec();
        return {bus.io_rsp_exception, bus.io_rsp_hit, bus.io_rsp_entry};
    endfunction

    task automatic run1(input string tag, input logic [1:0] prv, input longint addr, input int size,
                        input int kind, input logic [EW+1:0] exp);
        set_req(prv, addr, size, kind);
        bus.io_req_valid = 1'b1;
        bus.io_rsp_ready = 1'b1;
        @(posedge clock); #1;
        bus.io_req_valid = 1'b0;
        check({tag, "_early"}, bus.io_rsp_valid, 1'b0);
        @(posedge clock); #1;
        check({tag, "_valid"}, bus.io_rsp_valid, 1'b1);
        check({tag, "_rsp"}, rsp_vec(), exp);
        @(posedge clock); #1;
    endtask

    task automatic check_fault(input string tag, input logic v, input longint a);
`ifdef PMP_FAULT_LOG_EN
        check({tag, "_fault_valid"}, bus.io_fault_valid, v);
        check({tag, "_fault_addr"}, bus.io_fault_addr, PLEN'(a));
`else
        check({tag, "_fault_valid"}, bus.io_fault_valid, 1'b0);
        check({tag, "_fault_addr"}, bus.io_fault_addr, 0);
`endif
    endtask

    task automatic stream(input string tag, input int n, input bit rnd, input int st0, input int stn);
        logic [EW+1:0] q [$];
        logic [EW+2:0] prev;
        bit prev_stall, blocked;
        int sent, got, cyc;
        prev_stall = 0;
        blocked = 0;
        sent = 0;
        got = 0;
        cyc = 0;
        prev = '0;
        while ((sent < n || q.size() > 0) && cyc < 20 * n + 50) begin
            if (prev_stall) check({tag, "_hold"}, {bus.io_rsp_valid, rsp_vec()}, prev);
            bus.io_rsp_ready = rnd ? $urandom_range(0, 3) != 0 : !(cyc >= st0 && cyc < st0 + stn);
            bus.io_req_valid = sent < n;
            if (sent < n) rand_req();
            #1;
            if (bus.io_rsp_valid && bus.io_rsp_ready) begin
                check({tag, "_rsp_expected"}, q.size() != 0, 1'b1);
                if (q.size() != 0) check({tag, "_rsp"}, rsp_vec(), q.pop_front());
                got++;
            end
            prev_stall = bus.io_rsp_valid && !bus.io_rsp_ready;
            prev = {1'b1, rsp_vec()};
            if (bus.io_req_valid && !bus.io_req_ready) blocked = 1;
            if (bus.io_req_valid && bus.io_req_ready) begin
                q.push_back(ref_rsp(r_prv, r_addr, r_size, r_kind));
                sent++;
            end
            @(posedge clock); #1;
            cyc++;
        end
        bus.io_req_valid = 1'b0;
        check({tag, "_responses"}, got, n);
        check({tag, "_pending"}, q.size(), 0);
        if (!rnd) check({tag, "_ready_drop"}, blocked, 1'b1);
    endtask

    initial begin
        bus.io_req_valid = 1'b0;
        bus.io_rsp_ready = 1'b0;
        bus.io_fault_clr = 1'b0;
        set_req(2'd0, 0, 0, 0);
        clear_cfg();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_rsp_valid", bus.io_rsp_valid, 1'b0);
        check("rst_rsp", rsp_vec(), 0);
        check("rst_req_ready", bus.io_req_ready, 1'b1);
        check_fault("rst", 1'b0, 0);

        cfg[0] = 8'h19;
        paddr[0] = 'h1FF;
        apply_cfg();
        run1("napot_r", 2'd0, 'h400, 2, 0, {1'b0, 1'b1, 4'd0});
        check_fault("napot_r", 1'b0, 0);
        run1("napot_w", 2'd0, 'h400, 2, 1, {1'b1, 1'b1, 4'd0});
        check_fault("napot_w", 1'b1, 'h400);

        clear_cfg();
        cfg[1] = 8'h0F;
        paddr[0] = 'h100;
        paddr[1] = 'h200;
        apply_cfg();
        bus.io_fault_clr = 1'b1;
        run1("tor_partial", 2'd0, 'h7FE, 2, 0, {1'b1, 1'b1, 4'd1});
        bus.io_fault_clr = 1'b0;
        check_fault("clr_and_new", 1'b1, 'h7FE);

        clear_cfg();
        run1("off_m_w", 2'd3, 'h1234, 2, 1, {1'b0, 1'b0, 4'd0});
        run1("off_s_r", 2'd1, 'h1234, 0, 0, {1'b1, 1'b0, 4'd0});
        run1("off_prv2", 2'd2, 'h1234, 1, 0, {1'b1, 1'b0, 4'd0});
        check_fault("sticky", 1'b1, 'h7FE);
        bus.io_fault_clr = 1'b1;
        @(posedge clock); #1;
        bus.io_fault_clr = 1'b0;
        check_fault("cleared", 1'b0, 'h7FE);

        cfg[0] = 8'h93;
        paddr[0] = 'h200;
        cfg[1] = 8'h1F;
        paddr[1] = 'h1FF;
        apply_cfg();
        run1("lock_prio", 2'd3, 'h800, 2, 2, {1'b1, 1'b1, 4'd0});
        cfg[0] = 8'h13;
        apply_cfg();
        run1("m_unlocked", 2'd3, 'h800, 2, 2, {1'b0, 1'b1, 4'd0});

        rand_cfg();
        stream("b2b", 8, 1'b0, 3, 3);

        bus.io_req_valid = 1'b1;
        bus.io_rsp_ready = 1'b0;
        rand_req();
        repeat (3) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        bus.io_req_valid = 1'b0;
        check("midrst_rsp_valid", bus.io_rsp_valid, 1'b0);
        check("midrst_rsp", rsp_vec(), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        bus.io_rsp_ready = 1'b1;
        check("midrst_ready", bus.io_req_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            check("midrst_flush", bus.io_rsp_valid, 1'b0);
        end
        check_fault("midrst", 1'b0, 0);

        stream("rand", 400, 1'b1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
